mul8_seq_ctrl: RTL and testbench

//   Sequences one shared HALF_W x HALF_W unsigned array multiplier, such as the 4x4

---
 rtl/mul8_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl
//   Drives one shared HALF_W x HALF_W unsigned multiplier four times to build a
//   (2*HALF_W) x (2*HALF_W) unsigned product. The four partial products are
//   shift-accumulated into a 4*HALF_W-bit result.
//
//   Ports
//     clk, rst            rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready   operand handshake; in_a, in_b are 2*HALF_W bits
//     mul_en              high while a multiplier step is in progress
//     mul_a, mul_b        HALF_W-bit operands for the shared multiplier
//     mul_p               2*HALF_W-bit product from the shared multiplier
//     out_valid/out_ready result handshake; out_p is 4*HALF_W bits
//
//   Parameters
//     HALF_W   multiplier operand width
//     MUL_LAT  multiplier latency in cycles (0 = combinational mul_p)
module mul8_seq_ctrl #(
  parameter int HALF_W  = 4,
  parameter int MUL_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_a,
  input  logic [2*HALF_W-1:0]   in_b,
  output logic                  mul_en,
  output logic [HALF_W-1:0]     mul_a,
  output logic [HALF_W-1:0]     mul_b,
  input  logic [2*HALF_W-1:0]   mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   out_p
);

  localparam int FULL_W = 2 * HALF_W;
  localparam int ACC_W  = 4 * HALF_W;
  // Counter for the cycles a step's operands are held; at least one bit wide
  // so the MUL_LAT = 0 case still elaborates cleanly.
  localparam int CNT_W  = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MUL_LAT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_reg;
  logic [FULL_W-1:0] a_reg;
  logic [FULL_W-1:0] b_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [1:0]        step_reg;
  logic [CNT_W-1:0]  lat_reg;

  logic              in_step;
  logic              sample;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  addend;

  assign in_step = (state_reg == ST_STEP);
  // mul_p belongs to the current step only in the last cycle of the hold window.
  assign sample  = in_step && (lat_reg == LAT_LAST);

  // step bit 0 selects the high half of A, step bit 1 the high half of B:
  // 0: aL*bL, 1: aH*bL, 2: aL*bH, 3: aH*bH. Forced to zero outside STEP so the
  // shared core sees no toggling while this block is not using it.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (in_step) begin
      mul_a = step_reg[0] ? a_reg[FULL_W-1:HALF_W] : a_reg[HALF_W-1:0];
      mul_b = step_reg[1] ? b_reg[FULL_W-1:HALF_W] : b_reg[HALF_W-1:0];
    end
  end

  // Partial-product weight: the two cross terms share the same shift.
  always_comb begin
    prod_ext = ACC_W'(mul_p);
    addend   = prod_ext;
    case (step_reg)
      2'd0:    addend = prod_ext;
      2'd1,
      2'd2:    addend = prod_ext << HALF_W;
      default: addend = prod_ext << (2 * HALF_W);
    endcase
  end

  assign mul_en    = in_step;
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  // The accumulator is only exposed once complete, so no partial sum leaks out.
  assign out_p     = (state_reg == ST_DONE) ? acc_reg : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      step_reg  <= 2'd0;
      lat_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            acc_reg   <= '0;
            step_reg  <= 2'd0;
            lat_reg   <= '0;
            state_reg <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (sample) begin
            acc_reg <= acc_reg + addend;
            lat_reg <= '0;
            if (step_reg == 2'd3) begin
              state_reg <= ST_DONE;
            end else begin
              step_reg <= step_reg + 2'd1;
            end
          end else begin
            lat_reg <= lat_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
module tb_mul8_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Instance with a combinational multiplier (MUL_LAT = 0)
  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic [7:0]  in_a0 = 8'h00;
  logic [7:0]  in_b0 = 8'h00;
  logic        mul_en0;
  logic [3:0]  mul_a0;
  logic [3:0]  mul_b0;
  logic [7:0]  mul_p0;
  logic        out_valid0;
  logic        out_ready0 = 1'b1;
  logic [15:0] out_p0;

  // Instance with a two-stage registered multiplier (MUL_LAT = 2)
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  in_a2 = 8'h00;
  logic [7:0]  in_b2 = 8'h00;
  logic        mul_en2;
  logic [3:0]  mul_a2;
  logic [3:0]  mul_b2;
  logic [7:0]  mul_p2;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [15:0] out_p2;
  logic [7:0]  pipe1;
  logic [7:0]  pipe2;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] q0[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  assign mul_p0 = {4'b0, mul_a0} * {4'b0, mul_b0};

  always_ff @(posedge clk) begin
    pipe1 <= {4'b0, mul_a2} * {4'b0, mul_b2};
    pipe2 <= pipe1;
  end
  assign mul_p2 = pipe2;

  mul8_seq_ctrl #(.HALF_W(4), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .mul_en(mul_en0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0)
  );

  mul8_seq_ctrl #(.HALF_W(4), .MUL_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .mul_en(mul_en2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_p(out_p2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on dut0: accept, optionally check the nibble sequence,
  // check latency and the product. Leaves dut0 in DONE if out_ready0 is low.
  task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input bit chk_mul);
    int cyc;
    int s;
    logic [3:0]  ema;
    logic [3:0]  emb;
    logic [15:0] exp_p;
    in_a0 = a;
    in_b0 = b;
    in_valid0 = 1'b1;
    n_vec++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL accept0 %h*%h: in_ready=%b want 1", a, b, in_ready0);
    end
    q0.push_back(16'(a) * 16'(b));
    tick();
    in_valid0 = 1'b0;
    cyc = 1;
    while (out_valid0 !== 1'b1 && cyc < 60) begin
      if (chk_mul && cyc <= 4) begin
        s = cyc - 1;
        ema = (s % 2 == 0) ? a[3:0] : a[7:4];
        emb = (s < 2) ? b[3:0] : b[7:4];
        n_vec++;
        if ({mul_en0, mul_a0, mul_b0} !== {1'b1, ema, emb}) begin
          n_err++;
          $display("FAIL mulseq0 step%0d: en/a/b=%b/%h/%h want 1/%h/%h",
                   s, mul_en0, mul_a0, mul_b0, ema, emb);
        end
      end
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 5) begin
      n_err++;
      $display("FAIL latency0 %h*%h: out_valid after %0d cycles want 5", a, b, cyc);
    end
    n_vec++;
    if ({mul_en0, mul_a0, mul_b0} !== 9'd0) begin
      n_err++;
      $display("FAIL quiet0: en/a/b=%b/%h/%h want 0/0/0", mul_en0, mul_a0, mul_b0);
    end
    if (q0.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard0: unexpected output %h", out_p0);
    end else begin
      exp_p = q0.pop_front();
      n_vec++;
      if (out_p0 !== exp_p) begin
        n_err++;
        $display("FAIL product0 %h*%h: out_p=%h want %h", a, b, out_p0, exp_p);
      end else begin
        $display("op0 %h*%h -> %h", a, b, out_p0);
      end
    end
    if (out_ready0) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready0, out_valid0, out_p0, mul_en0, mul_a0, mul_b0} !== {1'b1, 26'd0}) begin
      n_err++;
      $display("FAIL reset0: rdy/ov/p/en/a/b=%b/%b/%h/%b/%h/%h want 1/0/0/0/0/0",
               in_ready0, out_valid0, out_p0, mul_en0, mul_a0, mul_b0);
    end
    n_vec++;
    if ({in_ready2, out_valid2, out_p2, mul_en2, mul_a2, mul_b2} !== {1'b1, 26'd0}) begin
      n_err++;
      $display("FAIL reset2: rdy/ov/p/en/a/b=%b/%b/%h/%b/%h/%h want 1/0/0/0/0/0",
               in_ready2, out_valid2, out_p2, mul_en2, mul_a2, mul_b2);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_max();
    run_op0(8'hFF, 8'hFF, 1'b1);
    run_op0(8'h00, 8'hFF, 1'b1);
  endtask

  task automatic test_sequence();
    run_op0(8'h12, 8'h34, 1'b1);
    run_op0(8'hA5, 8'h3C, 1'b1);
  endtask

  task automatic test_backpressure();
    out_ready0 = 1'b0;
    run_op0(8'h9D, 8'h47, 1'b0);
    in_a0 = 8'h55;
    in_b0 = 8'h66;
    in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({out_valid0, out_p0, in_ready0} !== {1'b1, 16'h9D * 16'h47, 1'b0}) begin
        n_err++;
        $display("FAIL hold0 cycle%0d: ov/p/rdy=%b/%h/%b want 1/%h/0",
                 i, out_valid0, out_p0, in_ready0, 16'h9D * 16'h47);
      end
      tick();
    end
    out_ready0 = 1'b1;
    tick();
    run_op0(8'h55, 8'h66, 1'b0);
  endtask

  task automatic test_async_reset();
    out_ready0 = 1'b0;
    run_op0(8'h9C, 8'h3B, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready0, out_valid0, out_p0, mul_en0, mul_a0, mul_b0} !== {1'b1, 26'd0}) begin
      n_err++;
      $display("FAIL midreset0: rdy/ov/p/en/a/b=%b/%b/%h/%b/%h/%h want 1/0/0/0/0/0",
               in_ready0, out_valid0, out_p0, mul_en0, mul_a0, mul_b0);
    end
    tick();
    rst = 1'b0;
    out_ready0 = 1'b1;
    run_op0(8'h21, 8'h43, 1'b1);
  endtask

  task automatic test_reset_in_step();
    in_a0 = 8'hAB;
    in_b0 = 8'hCD;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({mul_en0, mul_a0, mul_b0} !== {1'b1, 4'hB, 4'hC}) begin
      n_err++;
      $display("FAIL step2_0: en/a/b=%b/%h/%h want 1/b/c", mul_en0, mul_a0, mul_b0);
    end
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mul_en0, mul_a0, mul_b0, in_ready0} !== {9'd0, 1'b1}) begin
      n_err++;
      $display("FAIL stepreset0: en/a/b/rdy=%b/%h/%h/%b want 0/0/0/1",
               mul_en0, mul_a0, mul_b0, in_ready0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (out_valid0 !== 1'b0) begin
        n_err++;
        $display("FAIL discard0 cycle%0d: out_valid=%b want 0", i, out_valid0);
      end
      tick();
    end
    run_op0(8'h03, 8'h05, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    run_op0(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_op0(a, b, 1'b1);
    end
  endtask

  task automatic test_lat2();
    int cyc;
    int s;
    logic [3:0]  ema;
    logic [3:0]  emb;
    logic [15:0] exp_p;
    in_a2 = 8'h12;
    in_b2 = 8'h34;
    in_valid2 = 1'b1;
    n_vec++;
    if (in_ready2 !== 1'b1) begin
      n_err++;
      $display("FAIL accept2: in_ready=%b want 1", in_ready2);
    end
    q2.push_back(16'h0012 * 16'h0034);
    tick();
    in_valid2 = 1'b0;
    cyc = 1;
    while (out_valid2 !== 1'b1 && cyc < 60) begin
      if (cyc <= 12) begin
        s = (cyc - 1) / 3;
        ema = (s % 2 == 0) ? in_a2[3:0] : in_a2[7:4];
        emb = (s < 2) ? in_b2[3:0] : in_b2[7:4];
        n_vec++;
        if ({mul_en2, mul_a2, mul_b2} !== {1'b1, ema, emb}) begin
          n_err++;
          $display("FAIL mulseq2 cycle%0d: en/a/b=%b/%h/%h want 1/%h/%h",
                   cyc, mul_en2, mul_a2, mul_b2, ema, emb);
        end
      end
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 13) begin
      n_err++;
      $display("FAIL latency2: out_valid after %0d cycles want 13", cyc);
    end
    exp_p = (q2.size() > 0) ? q2.pop_front() : 16'hxxxx;
    n_vec++;
    if (out_p2 !== exp_p || out_p2 !== 16'h03A8) begin
      n_err++;
      $display("FAIL product2: out_p=%h want 03a8", out_p2);
    end else begin
      $display("op2 12*34 -> %h", out_p2);
    end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_max();
    test_sequence();
    test_backpressure();
    test_async_reset();
    test_reset_in_step();
    test_back_to_back();
    test_lat2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
